// File: rtl/adder_pkg.sv
// Shared defaults and FSM encoding for the multicycle 64-bit adder.
package adder_pkg;

    localparam int unsigned DEF_WIDTH  = 64;
    localparam int unsigned DEF_SLICE  = 16;
    localparam int unsigned DEF_NSLICE = DEF_WIDTH / DEF_SLICE;
    localparam int unsigned DEF_IDX_W  = $clog2(DEF_NSLICE);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full adders.
module rca_slice
    import adder_pkg::*;
#(
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [SLICE:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out    = carry[SLICE];
    // Carry into the top bit, used by the parent for signed overflow.
    assign c_msb_in = carry[SLICE-1];

endmodule

// File: rtl/multicycle_adder64.sv
// Sequential WIDTH-bit adder reusing one SLICE-bit ripple slice, LS slice first.
module multicycle_adder64
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("WIDTH must be an integer multiple of SLICE");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [SLICE-1:0]   slice_a, slice_b, slice_sum;
    logic               slice_cout, slice_cmsb;

    assign slice_a = a_q[idx_q*SLICE +: SLICE];
    assign slice_b = b_q[idx_q*SLICE +: SLICE];

    rca_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a       (slice_a),
        .b       (slice_b),
        .c_in    (carry_q),
        .sum     (slice_sum),
        .c_out   (slice_cout),
        .c_msb_in(slice_cmsb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                psum_d[idx_q*SLICE +: SLICE] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    // Final slice: publish the full result in the same edge.
                    idx_d   = '0;
                    sum_d   = psum_d;
                    c_out_d = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_adder64.sv
// Directed bench for multicycle_adder64 with a scoreboard of reference results.
module tb_multicycle_adder64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a, b;
    logic        c_in;
    logic        busy, done, c_out, overflow;
    logic [63:0] sum;

    typedef struct {
        logic [63:0] sum;
        logic        c_out;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_sum;

    multicycle_adder64 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .c_out   (c_out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 65-bit addition; overflow from operand/result signs.
    task automatic push(input logic [63:0] x, input logic [63:0] y, input logic ci);
        logic [64:0] r;
        exp_t        e;
        r       = {1'b0, x} + {1'b0, y} + {64'd0, ci};
        e.sum   = r[63:0];
        e.c_out = r[64];
        e.ovf   = (x[63] == y[63]) && (r[63] != x[63]);
        sb.push_back(e);
    endtask

    task automatic start_op(input logic [63:0] x, input logic [63:0] y, input logic ci);
        a     = x;
        b     = y;
        c_in  = ci;
        start = 1'b1;
        push(x, y, ci);
        tick();
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        c_in  = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, input int start_lat);
        int   lat;
        exp_t e;
        lat = start_lat;
        while (done !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sum"}, sum, e.sum);
            chk({tag, "_cout"}, 64'(c_out), 64'(e.c_out));
            chk({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
            chk({tag, "_busy_done"}, 64'(busy), 64'd1);
            last_sum = e.sum;
        end
        tick();
        chk({tag, "_done_drop"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        // Reset held with start asserted and random operands.
        rst   = 1'b1;
        start = 1'b1;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        c_in  = 1'($urandom);
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", 64'(c_out), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Release with start still high: first edge afterwards is the start edge.
        @(negedge clk);
        rst = 1'b0;
        push(a, b, c_in);
        tick();
        start = 1'b0;
        chk("rel_busy", 64'(busy), 64'd1);
        wait_done("rel_op", 0);

        start_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        wait_done("ones_c0", 0);
        chk("ones_c0_lit", last_sum, 64'hFFFFFFFFFFFFFFFE);

        start_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        wait_done("ones_c1", 0);

        start_op(64'h6A, 64'h4, 1'b0);
        wait_done("small", 0);
        chk("small_lit", last_sum, 64'h6E);

        start_op(64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0);
        // Previous result must hold until the next DONE load.
        tick();
        chk("hold_sum", sum, 64'h6E);
        wait_done("sovf", 1);

        start_op(64'h508BBE0301D2D287, 64'hDF181EA770DB8BB5, 1'b0);
        wait_done("mixed", 0);
        chk("mixed_lit", last_sum, 64'h2FA3DCAA72AE5E3C);

        // Start pulse during RUN with new operands must be ignored.
        start_op(64'h0000FFFF0000FFFF, 64'h0000000100000001, 1'b1);
        tick();
        a     = 64'h1234;
        b     = 64'h5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore", 2);
        tick();
        chk("ignore_no_restart", 64'(busy), 64'd0);

        // Reset at edge k+2 mid-RUN.
        start_op(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 1'b0);
        tick();
        @(posedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_sum", sum, 64'd0);
        chk("mrst_cout", 64'(c_out), 64'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mrst_quiet", 64'({busy, done}), 64'd0);
        end
        start_op(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 1'b1);
        wait_done("restart", 0);

        for (int i = 0; i < 4; i++) begin
            start_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            wait_done("rand", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
